// File: rtl/uart_pkg.sv
// Shared constants, frame timing helper and scheduler state encoding
// for the UART transmit buffer.
package uart_pkg;

    // Start bit + 8 data bits + 1 stop bit.
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } tx_state_e;

    function automatic int unsigned frame_cycles(
        input int unsigned clk_freq,
        input int unsigned baud,
        input int unsigned guard
    );
        return (clk_freq / baud) * (FRAME_BITS + guard);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead byte FIFO: head byte is visible on rd_data_o
// whenever the FIFO is non-empty; rd_i pops it on the next edge.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     rd_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ok;
    logic          rd_ok;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rptr_q];

    // Fullness is judged on the registered level, so a pop never frees
    // a slot for a write in the same cycle.
    assign wr_ok = wr_i && !full_o;
    assign rd_ok = rd_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus frame-pacing scheduler feeding uart_controller's TX side;
// enable pulses are spaced exactly one frame time apart.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
    parameter logic [31:0] UART_BAUD  = 32'd115200,
    parameter int          FIFO_DEPTH = 16,
    parameter int          STOP_GUARD = 1
) (
    input  logic                          uart_clk_in,
    input  logic                          reset,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          tx_busy,
    output logic [7:0]                    uart_tx_data,
    output logic                          uart_tx_enable
);

    localparam int unsigned FRAME_CYCLES =
        frame_cycles(CLK_FREQ, UART_BAUD, STOP_GUARD);
    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    // IDLE(pop) + SEND + HOLD span one frame, so HOLD lasts FRAME_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 3);

    tx_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           en_q, en_d;
    logic           ovf_q, ovf_d;
    logic           pop;
    logic [7:0]     head;

    uart_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (uart_clk_in),
        .rst_i     (reset),
        .wr_i      (wr_en),
        .wr_data_i (wr_data),
        .rd_i      (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign overflow       = ovf_q;
    assign tx_busy        = (state_q != ST_IDLE);
    assign uart_tx_data   = data_q;
    assign uart_tx_enable = en_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head;
                    en_d    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A dropped write outranks a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge uart_clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
